// File: rtl/io_1_pad_conditioner.sv
// ---------------------------------------------------------------------------
// io_1_pad_conditioner
//   Pad-side stage sitting between the external pad and the IO_1 BEL's
//   external ports. Registers drive data/enable onto the pad, synchronises
//   and deglitches the pad input back to the BEL, and freezes the input path
//   for a bus-turnaround window after the pad stops driving.
//
// Ports
//   UserCLK     in   fabric user clock, all state on posedge
//   resetn      in   asynchronous active-low reset
//   I_top       in   drive data from BEL
//   T_top       in   drive enable from BEL (1 = pad driven)
//   O_top       out  filtered pad level to BEL
//   pad_in      in   raw pad input, asynchronous to UserCLK
//   pad_out     out  registered drive data to pad buffer
//   pad_oe      out  registered output enable to pad buffer
//   rise_pulse  out  one-cycle pulse on filtered 0->1
//   fall_pulse  out  one-cycle pulse on filtered 1->0
// ---------------------------------------------------------------------------
module io_1_pad_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 4,
    parameter int TURNAROUND   = 2,
    parameter bit IN_RESET_VAL = 1'b0
) (
    input  logic UserCLK,
    input  logic resetn,
    input  logic I_top,
    input  logic T_top,
    output logic O_top,
    input  logic pad_in,
    output logic pad_out,
    output logic pad_oe,
    output logic rise_pulse,
    output logic fall_pulse
);

    // Turnaround counter: loaded with TURNAROUND-1, so it needs to hold
    // values up to TURNAROUND-1.
    localparam int TW    = (TURNAROUND > 2) ? $clog2(TURNAROUND) : 1;
    localparam int TLOAD = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;

    typedef enum logic [1:0] {ST_RX, ST_TX, ST_TURN} state_t;

    state_t                   r_state;
    logic [TW-1:0]            r_tcnt;
    logic                     r_oe;
    logic                     r_out;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_filt;
    logic                     r_rise;
    logic                     r_fall;
    logic                     w_s;
    logic                     w_run;

    // -----------------------------------------------------------------------
    // Drive path and turnaround FSM. pad_oe is registered alongside the
    // state so it is high exactly while the FSM sits in TX.
    // -----------------------------------------------------------------------
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RX;
            r_tcnt  <= '0;
            r_oe    <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_out <= I_top;
            case (r_state)
                ST_RX: begin
                    if (T_top) begin
                        r_state <= ST_TX;
                        r_oe    <= 1'b1;
                    end
                end
                ST_TX: begin
                    if (!T_top) begin
                        r_oe    <= 1'b0;
                        r_tcnt  <= TW'(TLOAD);
                        r_state <= (TURNAROUND == 0) ? ST_RX : ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (T_top) begin
                        // Re-drive aborts the turnaround window.
                        r_state <= ST_TX;
                        r_oe    <= 1'b1;
                    end else if (r_tcnt == '0) begin
                        r_state <= ST_RX;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RX;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Input synchroniser: shifts every cycle regardless of FSM state.
    // -----------------------------------------------------------------------
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_sync <= {SYNC_STAGES{IN_RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign w_s   = r_sync[SYNC_STAGES-1];
    // Filter state (level, counter, pulses) is frozen only during TURN.
    assign w_run = (r_state != ST_TURN);

    // -----------------------------------------------------------------------
    // Deglitch filter: a new level must be seen FILTER_LEN consecutive
    // cycles before it is accepted. Pulses are registered on the same edge
    // that updates the filtered level.
    // -----------------------------------------------------------------------
    if (FILTER_LEN > 0) begin : g_filt
        localparam int            CW       = $clog2(FILTER_LEN + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

        logic [CW-1:0] r_cnt;

        always_ff @(posedge UserCLK or negedge resetn) begin
            if (!resetn) begin
                r_cnt  <= '0;
                r_filt <= IN_RESET_VAL;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_run) begin
                    if (w_s == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_filt <= w_s;
                        r_cnt  <= '0;
                        r_rise <= w_s;
                        r_fall <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end else begin : g_bypass
        // With the filter bypassed, the filtered-level register takes the
        // place of the final synchroniser stage, so a pad step reaches O_top
        // after SYNC_STAGES edges.
        logic w_nxt;
        assign w_nxt = r_sync[SYNC_STAGES-2];

        always_ff @(posedge UserCLK or negedge resetn) begin
            if (!resetn) begin
                r_filt <= IN_RESET_VAL;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_run) begin
                    r_filt <= w_nxt;
                    r_rise <= w_nxt & ~r_filt;
                    r_fall <= ~w_nxt & r_filt;
                end
            end
        end
    end

    assign O_top      = r_filt;
    assign pad_out    = r_out;
    assign pad_oe     = r_oe;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

// File: tb/tb_io_1_pad_conditioner.sv
// ---------------------------------------------------------------------------
// tb_io_1_pad_conditioner
//   Directed bench: default-parameter instance (dut) for reset, glitch
//   rejection, drive, turnaround, abort and async reset; a second instance
//   (dut2) with FILTER_LEN=0, TURNAROUND=0 for the bypass configuration.
// ---------------------------------------------------------------------------
module tb_io_1_pad_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic I_top, T_top, pad_in;
    logic O_top, pad_out, pad_oe, rise_pulse, fall_pulse;
    logic I_top2, T_top2, pad_in2;
    logic O_top2, pad_out2, pad_oe2, rise2, fall2;

    int n_tot = 0;
    int n_bad = 0;
    logic seen;

    io_1_pad_conditioner dut (
        .UserCLK(clk), .resetn(resetn), .I_top(I_top), .T_top(T_top),
        .O_top(O_top), .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    io_1_pad_conditioner #(.FILTER_LEN(0), .TURNAROUND(0)) dut2 (
        .UserCLK(clk), .resetn(resetn), .I_top(I_top2), .T_top(T_top2),
        .O_top(O_top2), .pad_in(pad_in2), .pad_out(pad_out2), .pad_oe(pad_oe2),
        .rise_pulse(rise2), .fall_pulse(fall2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset, unclocked and held
        resetn = 1'b0; pad_in = 1'b1; T_top = 1'b1; I_top = 1'b0;
        pad_in2 = 1'b0; T_top2 = 1'b0; I_top2 = 1'b0;
        #3;
        chk("rst_oe_unclk", pad_oe, 1'b0);
        chk("rst_o_unclk", O_top, 1'b0);
        chk("rst_out_unclk", pad_out, 1'b0);
        tick(2);
        chk("rst_oe_held", pad_oe, 1'b0);
        chk("rst_o_held", O_top, 1'b0);
        chk("rst_rise_held", rise_pulse, 1'b0);
        T_top = 1'b0;
        resetn = 1'b1;
        tick(5);
        chk("rel_o_e5", O_top, 1'b0);
        tick(1);
        chk("rel_o_e6", O_top, 1'b1);
        chk("rel_rise_e6", rise_pulse, 1'b1);
        chk("rel_fall_e6", fall_pulse, 1'b0);
        tick(1);
        chk("rel_rise_e7", rise_pulse, 1'b0);
        chk("rel_o_e7", O_top, 1'b1);

        // ---- 2: glitch rejection
        pad_in = 1'b0;
        tick(6);
        chk("fall_o_e6", O_top, 1'b0);
        chk("fall_pulse_e6", fall_pulse, 1'b1);
        tick(1);
        pad_in = 1'b1;
        tick(3);
        pad_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen |= O_top | rise_pulse | fall_pulse;
        end
        chk("glitch3_reject", seen, 1'b0);
        pad_in = 1'b1;
        tick(4);
        pad_in = 1'b0;
        tick(1);
        chk("glitch4_o_e5", O_top, 1'b0);
        tick(1);
        chk("glitch4_o_e6", O_top, 1'b1);
        chk("glitch4_rise", rise_pulse, 1'b1);
        tick(10);
        chk("glitch4_settle", O_top, 1'b0);

        // ---- 3: drive path
        T_top = 1'b1; I_top = 1'b1; pad_in = 1'b1;
        chk("drv_oe_pre", pad_oe, 1'b0);
        tick(1);
        chk("drv_oe", pad_oe, 1'b1);
        chk("drv_out1", pad_out, 1'b1);
        I_top = 1'b0;
        tick(1);
        chk("drv_out0", pad_out, 1'b0);
        I_top = 1'b1;
        tick(1);
        chk("drv_out1b", pad_out, 1'b1);
        tick(3);
        chk("drv_readback", O_top, 1'b1);
        tick(1);

        // ---- 4: turnaround freeze
        T_top = 1'b0; pad_in = 1'b0;
        tick(1);
        chk("turn_oe", pad_oe, 1'b0);
        chk("turn_o_e0", O_top, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            seen |= ~O_top | rise_pulse | fall_pulse;
        end
        chk("turn_hold", seen, 1'b0);
        tick(1);
        chk("turn_o_e6", O_top, 1'b0);
        chk("turn_fall", fall_pulse, 1'b1);

        // ---- 5: abort turnaround
        T_top = 1'b1;
        tick(1);
        chk("abort_tx", pad_oe, 1'b1);
        T_top = 1'b0;
        tick(1);
        chk("abort_turn", pad_oe, 1'b0);
        T_top = 1'b1;
        tick(1);
        chk("abort_retx", pad_oe, 1'b1);

        // ---- 6: async reset while driving
        pad_in = 1'b1;
        tick(7);
        chk("ares_pre_o", O_top, 1'b1);
        chk("ares_pre_oe", pad_oe, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ares_oe", pad_oe, 1'b0);
        chk("ares_o", O_top, 1'b0);
        T_top = 1'b0; pad_in = 1'b0;
        resetn = 1'b1;
        tick(1);
        chk("ares_after", pad_oe, 1'b0);

        // ---- 7: bypass filter, no turnaround
        T_top2 = 1'b1;
        tick(1);
        chk("byp_oe", pad_oe2, 1'b1);
        T_top2 = 1'b0; pad_in2 = 1'b1;
        tick(1);
        chk("byp_oe_off", pad_oe2, 1'b0);
        chk("byp_o_e1", O_top2, 1'b0);
        tick(1);
        chk("byp_o_e2", O_top2, 1'b1);
        chk("byp_rise", rise2, 1'b1);
        T_top2 = 1'b1;
        tick(1);
        chk("byp_redrive", pad_oe2, 1'b1);
        pad_in2 = 1'b0;
        tick(1);
        chk("byp_fall_e1", O_top2, 1'b1);
        tick(1);
        chk("byp_fall_e2", O_top2, 1'b0);
        chk("byp_fall", fall2, 1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
